// File: rtl/pll_lock_ctrl.sv
// PLL lock controller: settles the PFD, scores fixed-length up/dn error windows,
// steps the VCO coarse band when far off, and declares/drops lock with hysteresis.
module pll_lock_ctrl #(
    parameter int SETTLE     = 16,
    parameter int WIN_LEN    = 64,
    parameter int ERR_THR    = 4,
    parameter int ERR_MAX    = 32,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2
) (
    input  logic       clk1,
    input  logic       rst,
    input  logic       en,
    input  logic       up,
    input  logic       dn,
    output logic       pfd_en,
    output logic       lock,
    output logic [2:0] band,
    output logic       band_stb,
    output logic [1:0] state
);

    // state  | meaning
    // IDLE   | loop disabled, PFD gated off
    // SETTLE | PFD running, waiting SETTLE cycles before scoring windows
    // ACQ    | scoring windows, stepping band, counting good windows to lock
    // LOCKED | locked, counting bad windows to unlock
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_ACQ    = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

    localparam int CW = $clog2(WIN_LEN) + 1;
    localparam int EW = CW + 1;
    localparam int SW = $clog2(SETTLE) + 1;
    localparam int GW = $clog2(LOCK_CNT) + 1;
    localparam int BW = $clog2(UNLOCK_CNT) + 1;

    localparam logic [CW-1:0] WIN_END_V = CW'(WIN_LEN - 1);
    localparam logic [SW-1:0] SET_END_V = SW'(SETTLE - 1);
    localparam logic [EW-1:0] THR_V     = EW'(ERR_THR);
    localparam logic [EW-1:0] MAX_V     = EW'(ERR_MAX);
    localparam logic [GW-1:0] LOCK_V    = GW'(LOCK_CNT);
    localparam logic [BW-1:0] UNLOCK_V  = BW'(UNLOCK_CNT);

    logic          up_m, up_s, dn_m, dn_s;
    state_t        state_q, state_d;
    logic [SW-1:0] settle_cnt, settle_d;
    logic [CW-1:0] win_cnt, win_d;
    logic [CW-1:0] up_cnt, up_d, up_nxt;
    logic [CW-1:0] dn_cnt, dn_d, dn_nxt;
    logic [GW-1:0] good_cnt, good_d, good_inc;
    logic [BW-1:0] bad_cnt, bad_d, bad_inc;
    logic          lock_d, stb_d, pfd_en_d;
    logic [2:0]    band_d;
    logic [EW-1:0] err;
    logic          win_end, win_good;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            up_m       <= 1'b0;
            up_s       <= 1'b0;
            dn_m       <= 1'b0;
            dn_s       <= 1'b0;
            state_q    <= S_IDLE;
            settle_cnt <= '0;
            win_cnt    <= '0;
            up_cnt     <= '0;
            dn_cnt     <= '0;
            good_cnt   <= '0;
            bad_cnt    <= '0;
            lock       <= 1'b0;
            band       <= 3'd4;
            band_stb   <= 1'b0;
            pfd_en     <= 1'b0;
        end else begin
            up_m       <= up;
            up_s       <= up_m;
            dn_m       <= dn;
            dn_s       <= dn_m;
            state_q    <= state_d;
            settle_cnt <= settle_d;
            win_cnt    <= win_d;
            up_cnt     <= up_d;
            dn_cnt     <= dn_d;
            good_cnt   <= good_d;
            bad_cnt    <= bad_d;
            lock       <= lock_d;
            band       <= band_d;
            band_stb   <= stb_d;
            pfd_en     <= pfd_en_d;
        end
    end

    // The closing cycle's sample is folded in before the window is judged.
    always_comb begin
        up_nxt   = up_cnt + CW'(up_s & ~dn_s);
        dn_nxt   = dn_cnt + CW'(dn_s & ~up_s);
        err      = EW'(up_nxt) + EW'(dn_nxt);
        win_end  = (win_cnt == WIN_END_V);
        win_good = (err <= THR_V);
        good_inc = good_cnt + GW'(1);
        bad_inc  = bad_cnt + BW'(1);
    end

    always_comb begin
        state_d  = state_q;
        settle_d = settle_cnt;
        win_d    = '0;
        up_d     = '0;
        dn_d     = '0;
        good_d   = good_cnt;
        bad_d    = bad_cnt;
        lock_d   = lock;
        band_d   = band;
        stb_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                lock_d   = 1'b0;
                good_d   = '0;
                bad_d    = '0;
                settle_d = '0;
                if (en) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                settle_d = settle_cnt + SW'(1);
                if (settle_cnt == SET_END_V) begin
                    settle_d = '0;
                    state_d  = S_ACQ;
                end
            end
            S_ACQ, S_LOCKED: begin
                win_d = win_cnt + CW'(1);
                up_d  = up_nxt;
                dn_d  = dn_nxt;
                if (win_end) begin
                    win_d = '0;
                    up_d  = '0;
                    dn_d  = '0;
                    if (state_q == S_ACQ) begin
                        if (win_good) begin
                            if (good_inc == LOCK_V) begin
                                state_d = S_LOCKED;
                                lock_d  = 1'b1;
                                good_d  = '0;
                                bad_d   = '0;
                            end else begin
                                good_d = good_inc;
                            end
                        end else begin
                            good_d = '0;
                            if (err > MAX_V) begin
                                if (up_nxt > dn_nxt && band != 3'd7) begin
                                    band_d   = band + 3'd1;
                                    stb_d    = 1'b1;
                                    state_d  = S_SETTLE;
                                    settle_d = '0;
                                end else if (dn_nxt > up_nxt && band != 3'd0) begin
                                    band_d   = band - 3'd1;
                                    stb_d    = 1'b1;
                                    state_d  = S_SETTLE;
                                    settle_d = '0;
                                end
                            end
                        end
                    end else begin
                        // Band is frozen while locked; a large error is just a bad window.
                        if (win_good) begin
                            bad_d = '0;
                        end else if (bad_inc == UNLOCK_V) begin
                            state_d = S_ACQ;
                            lock_d  = 1'b0;
                            good_d  = '0;
                            bad_d   = '0;
                        end else begin
                            bad_d = bad_inc;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Disable wins over any window decision made on the same edge.
        if (!en) begin
            state_d  = S_IDLE;
            settle_d = '0;
            win_d    = '0;
            up_d     = '0;
            dn_d     = '0;
            good_d   = '0;
            bad_d    = '0;
            lock_d   = 1'b0;
            band_d   = band;
            stb_d    = 1'b0;
        end

        pfd_en_d = (state_d != S_IDLE);
    end

    assign state = state_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Bench for pll_lock_ctrl: a table of per-window up/dn patterns with hand-computed
// outcomes, followed by reset, lock-timing and disable sequences.
module tb_pll_lock_ctrl;

    logic       clk1 = 1'b0;
    logic       rst, en, up, dn;
    logic       pfd_en, lock, band_stb;
    logic [2:0] band;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    pll_lock_ctrl dut (
        .clk1    (clk1),
        .rst     (rst),
        .en      (en),
        .up      (up),
        .dn      (dn),
        .pfd_en  (pfd_en),
        .lock    (lock),
        .band    (band),
        .band_stb(band_stb),
        .state   (state)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        int nu;
        int nd;
        int nb;
        int st;
        int lk;
        int bd;
        int stb;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk1);
            #1;
        end
    endtask

    // One 64-cycle window starting in its first cycle; pulses sit well inside it
    // so synchronizer latency never pushes a sample across a window boundary.
    task automatic win(input int nu, input int nd, input int nb);
        for (int i = 0; i < 64; i++) begin
            up = (i >= 4 && i < 4 + nu) || (i >= 4 + nu + nd && i < 4 + nu + nd + nb);
            dn = (i >= 4 + nu && i < 4 + nu + nd + nb);
            @(posedge clk1);
            #1;
        end
        up = 1'b0;
        dn = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, state, 0);
        chk({tag, "_pfd_en"}, pfd_en, 0);
        chk({tag, "_lock"}, lock, 0);
        chk({tag, "_band"}, band, 4);
        chk({tag, "_stb"}, band_stb, 0);
    endtask

    // Enable at the next edge and confirm SETTLE lasts exactly 16 cycles.
    task automatic enable_and_settle(input string tag);
        en = 1'b1;
        tick(1);
        chk({tag, "_settle_state"}, state, 1);
        chk({tag, "_settle_pfd"}, pfd_en, 1);
        tick(15);
        chk({tag, "_settle_last"}, state, 1);
        tick(1);
        chk({tag, "_acq_state"}, state, 2);
    endtask

    initial begin
        //        nu  nd  nb  st lk bd stb
        tbl[0]  = '{4,  0,  0, 2, 0, 4, 0};
        tbl[1]  = '{5,  0,  0, 2, 0, 4, 0};
        tbl[2]  = '{0,  0, 20, 2, 0, 4, 0};
        tbl[3]  = '{2,  2,  0, 2, 0, 4, 0};
        tbl[4]  = '{0,  0,  0, 2, 0, 4, 0};
        tbl[5]  = '{3,  0,  0, 3, 1, 4, 0};
        tbl[6]  = '{10, 0,  0, 3, 1, 4, 0};
        tbl[7]  = '{0,  0,  0, 3, 1, 4, 0};
        tbl[8]  = '{0, 10,  0, 3, 1, 4, 0};
        tbl[9]  = '{40, 0,  0, 2, 0, 4, 0};
        tbl[10] = '{40, 0,  0, 1, 0, 5, 1};
        tbl[11] = '{36, 0,  0, 1, 0, 6, 1};
        tbl[12] = '{40, 0,  0, 1, 0, 7, 1};
        tbl[13] = '{40, 0,  0, 2, 0, 7, 0};
        tbl[14] = '{20, 20, 0, 2, 0, 7, 0};
        tbl[15] = '{0, 40,  0, 1, 0, 6, 1};
        tbl[16] = '{10, 30, 0, 1, 0, 5, 1};
        tbl[17] = '{33, 0,  0, 1, 0, 6, 1};
        tbl[18] = '{32, 0,  0, 2, 0, 6, 0};

        rst = 1'b1;
        en  = 1'b0;
        up  = 1'b0;
        dn  = 1'b0;
        #12;
        chk_reset_vals("rst0");
        @(posedge clk1);
        #1;
        rst = 1'b0;
        tick(2);
        chk("idle_hold", state, 0);

        enable_and_settle("run1");
        for (int k = 0; k < 19; k++) begin
            win(tbl[k].nu, tbl[k].nd, tbl[k].nb);
            chk($sformatf("w%0d_state", k), state, tbl[k].st);
            chk($sformatf("w%0d_lock", k), lock, tbl[k].lk);
            chk($sformatf("w%0d_band", k), band, tbl[k].bd);
            chk($sformatf("w%0d_stb", k), band_stb, tbl[k].stb);
            chk($sformatf("w%0d_pfd", k), pfd_en, 1);
            if (tbl[k].st == 1) begin
                tick(1);
                chk($sformatf("w%0d_stb_off", k), band_stb, 0);
                tick(15);
                chk($sformatf("w%0d_resettle", k), state, 2);
            end
        end

        // Async reset mid-window at band 6, checked before any clock edge.
        up = 1'b1;
        tick(10);
        #3;
        rst = 1'b1;
        #1;
        chk_reset_vals("arst");
        up = 1'b0;
        en = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("arst_idle", state, 0);

        // Fresh lock after reset: exactly four quiet windows.
        enable_and_settle("run2");
        for (int k = 0; k < 3; k++) win(0, 0, 0);
        chk("run2_pre_lock_state", state, 2);
        chk("run2_pre_lock", lock, 0);
        win(0, 0, 0);
        chk("run2_lock_state", state, 3);
        chk("run2_lock", lock, 1);

        // Disable while locked with a partly filled window.
        up = 1'b1;
        tick(10);
        up = 1'b0;
        en = 1'b0;
        tick(1);
        chk("dis_state", state, 0);
        chk("dis_pfd", pfd_en, 0);
        chk("dis_lock", lock, 0);
        chk("dis_band", band, 4);

        // Re-enable: partial window must be gone, so lock again takes four windows.
        enable_and_settle("run3");
        for (int k = 0; k < 3; k++) win(0, 0, 0);
        chk("run3_pre_lock", lock, 0);
        win(0, 0, 0);
        chk("run3_lock", lock, 1);
        chk("run3_state", state, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule
